// File: rtl/case_code_encoder.sv
// Streams fully-known 3-bit codes of a requested wildcard class over valid/ready.
// Per-class rotation pointers persist across bursts so every class member appears.
module case_code_encoder #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_vld,
  input  logic [1:0]       req_cls,
  input  logic [CNT_W-1:0] req_cnt,
  output logic             req_rdy,
  output logic [2:0]       code,
  output logic [1:0]       code_cls,
  output logic             code_vld,
  input  logic             code_rdy,
  output logic             last,
  output logic             busy
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e           state_q, state_d;
  logic [1:0]       cls_q, cls_d;
  logic [1:0]       ptr1_q, ptr1_d;
  logic             ptr2_q, ptr2_d;
  logic [CNT_W:0]   rem_q, rem_d;
  logic [2:0]       code_q, code_d;
  logic             last_q, last_d;

  function automatic logic [2:0] code_of(input logic [1:0] c,
                                         input logic [1:0] p1,
                                         input logic       p2);
    case (c)
      2'd0:    code_of = {1'b0, p1};
      2'd1:    code_of = {2'b10, p2};
      2'd2:    code_of = 3'b111;
      default: code_of = 3'b110;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    ptr1_d  = ptr1_q;
    ptr2_d  = ptr2_q;
    rem_d   = rem_q;
    code_d  = code_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req_vld) begin
          cls_d   = req_cls;
          rem_d   = (req_cnt == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, req_cnt};
          code_d  = code_of(req_cls, ptr1_q, ptr2_q);
          last_d  = (rem_d == (CNT_W+1)'(1));
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (code_rdy) begin
          if (cls_q == 2'd0) ptr1_d = ptr1_q + 2'd1;
          if (cls_q == 2'd1) ptr2_d = ~ptr2_q;
          rem_d = rem_q - (CNT_W+1)'(1);
          if (last_q) begin
            state_d = IDLE;
            code_d  = '0;
            last_d  = 1'b0;
          end else begin
            // Next code is built from the already-advanced pointers so the
            // registered output is ready the cycle after the handshake.
            code_d = code_of(cls_q, ptr1_d, ptr2_d);
            last_d = (rem_d == (CNT_W+1)'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cls_q   <= '0;
      ptr1_q  <= '0;
      ptr2_q  <= 1'b0;
      rem_q   <= '0;
      code_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      ptr1_q  <= ptr1_d;
      ptr2_q  <= ptr2_d;
      rem_q   <= rem_d;
      code_q  <= code_d;
      last_q  <= last_d;
    end
  end

  assign req_rdy  = (state_q == IDLE);
  assign busy     = (state_q == EMIT);
  assign code_vld = (state_q == EMIT);
  assign code     = code_q;
  assign code_cls = cls_q;
  assign last     = last_q;

endmodule
